// File: rtl/mem_stage_ctrl_pkg.sv
// mem_stage_ctrl_pkg: shared Funct3 encodings, counter width and FSM states for the M-stage memory bridge
package mem_stage_ctrl_pkg;
  localparam int CNT_W = 8;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/mem_stage_ctrl_align.sv
// mem_align: load extract/extend, store lane replication/byte enables, access legality
module mem_align
  import mem_stage_ctrl_pkg::*;
(
  input  logic        i_load,
  input  logic        i_store,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_rdata,
  output logic [31:0] o_wdata,
  output logic [3:0]  o_be,
  output logic        o_legal
);
  logic [31:0] w_shift;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [1:0]  w_size;
  logic        w_f3_ok;
  logic        w_aligned;
  // formatting and legality are pure functions of size, lane and raw data
  always_comb begin
    w_shift   = i_rdata >> {i_lane, 3'b000};
    w_byte    = w_shift[7:0];
    w_half    = i_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
    w_size    = i_funct3[1:0];
    o_rdata   = (i_funct3 == F3_B)  ? {{24{w_byte[7]}}, w_byte} :
                (i_funct3 == F3_BU) ? {24'b0, w_byte} :
                (i_funct3 == F3_H)  ? {{16{w_half[15]}}, w_half} :
                (i_funct3 == F3_HU) ? {16'b0, w_half} : i_rdata;
    o_wdata   = (w_size == 2'b00) ? {4{i_wdata[7:0]}} :
                (w_size == 2'b01) ? {2{i_wdata[15:0]}} : i_wdata;
    o_be      = (w_size == 2'b00) ? 4'b0001 << i_lane :
                (w_size == 2'b01) ? 4'b0011 << i_lane : 4'b1111;
    w_f3_ok   = i_load ? (i_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) : (i_funct3 <= F3_W);
    w_aligned = (w_size == 2'b10) ? (i_lane == 2'b00) :
                (w_size == 2'b01) ? !i_lane[0] : 1'b1;
    o_legal   = (i_load | i_store) & w_f3_ok & w_aligned;
  end
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: M-stage bridge between the pipeline and a variable-latency req/ack data memory
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        FaultM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > (1 << CNT_W) - 1) begin : g_bad_timeout
    $error("TIMEOUT_CYC must fit the busy counter");
  end
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [31:0] r_rdata;
  logic [31:0] w_rdata, w_wdata;
  logic [3:0]  w_be;
  logic        w_legal, w_access, w_timeout;
  logic [2:0]  w_funct3;
  logic [1:0]  w_lane;
  // fields come from the live inputs while idle and from the latched copy while the access is in flight
  always_comb begin
    w_access  = MemReadM | MemWriteM;
    w_funct3  = (r_state == IDLE) ? Funct3M : r_funct3;
    w_lane    = (r_state == IDLE) ? ALUResultM[1:0] : r_lane;
    w_timeout = (r_state == BUSY) && !mem_ack && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));
  end
  mem_align u_align (
    .i_load  (MemReadM),
    .i_store (MemWriteM),
    .i_funct3(w_funct3),
    .i_lane  (w_lane),
    .i_wdata (WriteDataM),
    .i_rdata (mem_rdata),
    .o_rdata (w_rdata),
    .o_wdata (w_wdata),
    .o_be    (w_be),
    .o_legal (w_legal)
  );
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end
  // next state: ack beats a simultaneous timeout since both lead to DONE and the fault is gated by !mem_ack
  always_comb begin
    w_next = (r_state == IDLE) ? ((w_access && w_legal) ? BUSY : IDLE) :
             (r_state == BUSY) ? ((mem_ack || w_timeout) ? DONE : BUSY) : IDLE;
  end
  // pipeline-facing outputs, forced quiet while reset is held
  always_comb begin
    StallM    = reset && (((r_state == IDLE) && w_access && w_legal) || (r_state == BUSY));
    FaultM    = reset && (((r_state == IDLE) && w_access && !w_legal) || w_timeout);
    ReadDataM = (r_state == DONE) ? r_rdata : '0;
  end
  // bus request registers, busy counter and captured load data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      r_cnt     <= '0;
      r_funct3  <= '0;
      r_lane    <= '0;
      r_rdata   <= '0;
    end else begin
      if (r_state == IDLE && w_next == BUSY) begin
        mem_req   <= 1'b1;
        mem_we    <= MemWriteM;
        mem_addr  <= {ALUResultM[31:2], 2'b00};
        mem_wdata <= MemWriteM ? w_wdata : '0;
        mem_be    <= w_be;
        r_funct3  <= Funct3M;
        r_lane    <= ALUResultM[1:0];
        r_cnt     <= '0;
      end
      if (r_state == BUSY) begin
        r_cnt <= r_cnt + 1'b1;
        if (mem_ack || w_timeout) begin
          mem_req <= 1'b0;
          r_rdata <= (mem_ack && !mem_we) ? w_rdata : '0;
          r_cnt   <= '0;
        end
      end
    end
  end
endmodule
